fft8_loader: RTL and testbench

- Upstream feeder for the 8-point FFT engine (afft8).
- Accepts a stream of complex samples over a valid/ready handshake and writes each frame of 8 into the engine's shared sample memory in bit-reversed order.
- Pulses the engine's start once the frame is written, then holds off new input until the engine reports done.
- Sits between the sample source (ADC/capture logic) and afft8's memory port.

---
 rtl/fft8_pkg.sv | 32 +++
 rtl/fft8_loader.sv | 151 +++++++++++++++
 tb/tb_fft8_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared constants, state encoding and bit-reversal helper for the 8-point FFT loader
//
// Purpose: shared definitions imported by fft8_loader.
//   N, LOG2N          : frame size and index width
//   ST_LOAD/START/WAIT: state encoding, wrapped by state_t
//   RE_*/IM_*         : field positions of {re, im} inside a 32-bit sample
//   bitrev3()         : reverses a 3-bit frame index into a memory offset
package fft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    LOAD  = ST_LOAD,
    START = ST_START,
    WAIT  = ST_WAIT
  } state_t;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] i_idx);
    return {i_idx[0], i_idx[1], i_idx[2]};
  endfunction

endpackage

// File: rtl/fft8_loader.sv
// rtl/fft8_loader.sv - streams 8-sample frames into afft8 memory in bit-reversed order and starts the engine
//
// Purpose: accepts complex samples over valid/ready, writes each frame of 8
// into the engine's shared sample memory at BASE_ADDR + bitrev3(idx), pulses
// fft_start one cycle after the last write, then blocks input until fft_done.
//
// Optional build macro: FFT8_LOADER_PRESCALE_EN
//   defined   : re and im are each arithmetic-shifted right by 3 before the write
//   undefined : samples are written unchanged
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   input sample valid
//   s_ready    out  loader accepts a sample this cycle (registered)
//   s_data     in   input sample {re[31:16], im[15:0]}
//   mem_req    out  one-cycle memory write request
//   mem_we     out  write enable, identical to mem_req
//   mem_addr   out  write address
//   mem_wdata  out  write data
//   fft_start  out  one-cycle start pulse to afft8
//   fft_done   in   afft8 frame-complete (pulse or level), sampled in WAIT only
//   busy       out  high from first accepted sample until fft_done is seen
//   frame_cnt  out  completed frame counter, wraps
import fft8_pkg::*;

module fft8_loader #(
  parameter int             AW        = 16,
  parameter int             DW        = 32,
  parameter logic [AW-1:0]  BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          fft_start,
  input  logic          fft_done,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LOG2N-1:0]   r_idx;
  logic               r_s_ready;
  logic               r_mem_req;
  logic [AW-1:0]      r_mem_addr;
  logic [DW-1:0]      r_mem_wdata;
  logic               r_fft_start;
  logic               r_busy;
  logic [15:0]        r_frame_cnt;

  logic               w_xfer;
  logic               w_frame_done;
  logic [DW-1:0]      w_wdata;
  logic [AW-1:0]      w_addr;

  // r_s_ready is only ever set when heading into LOAD; the state term keeps
  // writes confined to LOAD even if that invariant were broken.
  assign w_xfer = s_valid & r_s_ready & (r_state == LOAD);

  assign w_addr = BASE_ADDR + {{(AW-LOG2N){1'b0}}, bitrev3(r_idx)};

`ifdef FFT8_LOADER_PRESCALE_EN
  // 1/8 pre-scale keeps three radix-2 stages from overflowing 16 bits.
  assign w_wdata = {{3{s_data[RE_MSB]}}, s_data[RE_MSB:RE_LSB+3],
                    {3{s_data[IM_MSB]}}, s_data[IM_MSB:IM_LSB+3]};
`else
  assign w_wdata = s_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_xfer && (r_idx == LOG2N'(N-1))) begin
          w_state_nxt = START;
        end
      end
      // Last write is on the bus during START; start follows one cycle later.
      START: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          w_state_nxt  = LOAD;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_s_ready   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fft_start <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // Ready is a registered look-ahead of the next state, so it is low in
      // the first cycle after reset and drops the cycle after the 8th transfer.
      r_s_ready   <= (w_state_nxt == LOAD);
      r_mem_req   <= w_xfer;
      r_fft_start <= (r_state == START);
      if (w_xfer) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
        r_idx       <= r_idx + 1'b1;
      end
      if (w_xfer) begin
        r_busy <= 1'b1;
      end else if (w_frame_done) begin
        r_busy <= 1'b0;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign fft_start = r_fft_start;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft8_loader.sv
// tb/tb_fft8_loader.sv - scoreboard testbench for fft8_loader with randomized samples
module tb_fft8_loader;

  localparam int          AW   = 16;
  localparam int          DW   = 32;
  localparam logic [15:0] BASE = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          fft_start;
  logic          fft_done = 1'b0;
  logic          busy;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          model_idx = 0;
  int          rev_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [15:0] exp_frames = 16'd0;
  int          start_cnt = 0;

  always #5 clk = ~clk;

  fft8_loader #(.AW(AW), .DW(DW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference scaling: floor division by 8 of each signed half.
  function automatic logic [31:0] scale(input logic [31:0] d);
`ifdef FFT8_LOADER_PRESCALE_EN
    int re;
    int im;
    re = $signed(d[31:16]);
    im = $signed(d[15:0]);
    re = (re - (((re % 8) + 8) % 8)) / 8;
    im = (im - (((im % 8) + 8) % 8)) / 8;
    return {re[15:0], im[15:0]};
`else
    return d;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever a write appears on the memory bus.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (fft_start) start_cnt++;
      if (mem_req) begin
        chk("q_nonempty", (exp_q.size() != 0), 1'b1);
        chk("no_write_with_start", fft_start, 1'b0);
        chk("wr_we", mem_we, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
      end
    end
  end

  // One cycle of stimulus, starting and ending at a falling edge.
  task automatic drive_cycle(input logic v, input logic [31:0] d, output logic xfer);
    wr_t e;
    s_valid = v;
    s_data  = d;
    xfer = v && s_ready && !rst;
    if (xfer) begin
      e.a = BASE + 16'(rev_tab[model_idx]);
      e.d = scale(d);
      exp_q.push_back(e);
      model_idx = (model_idx + 1) % 8;
    end
    @(negedge clk);
    if (!rst) chk("mem_req_follows_xfer", mem_req, xfer);
  endtask

  task automatic send_sample(input logic [31:0] d, output int cycles);
    logic x;
    logic got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      drive_cycle(1'b1, d, x);
      cycles++;
      got = x;
    end
    chk("xfer_timeout", got, 1'b1);
  endtask

  // Called right after the 8th transfer's cycle: checks the start pulse timing.
  task automatic finish_frame(input bit done_held);
    logic x;
    int   sc0;
    sc0 = start_cnt;
    chk("start_n1", fft_start, 1'b0);
    chk("ready_n1", s_ready, 1'b0);
    chk("busy_n1", busy, 1'b1);
    drive_cycle(1'b0, 32'h0, x);
    chk("start_n2", fft_start, 1'b1);
    drive_cycle(1'b0, 32'h0, x);
    chk("start_n3", fft_start, 1'b0);
    chk("start_once", start_cnt, sc0 + 1);
    if (done_held) begin
      exp_frames = exp_frames + 16'd1;
      chk("frame_cnt_held", frame_cnt, exp_frames);
      chk("busy_after_done", busy, 1'b0);
      chk("ready_after_done", s_ready, 1'b1);
    end else begin
      chk("ready_wait", s_ready, 1'b0);
      chk("busy_wait", busy, 1'b1);
    end
  endtask

  task automatic done_pulse();
    logic x;
    fft_done = 1'b1;
    drive_cycle(1'b0, 32'h0, x);
    fft_done = 1'b0;
    exp_frames = exp_frames + 16'd1;
    chk("frame_cnt_pulse", frame_cnt, exp_frames);
    chk("busy_cleared", busy, 1'b0);
    chk("ready_back", s_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_fft_start", fft_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    exp_q.delete();
    model_idx = 0;
    exp_frames = 16'd0;
    rst = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random gaps, with random data
  // when rnd is set; first holds an explicit first-sample value.
  task automatic send_frame(input int mode, input bit rnd, input logic [31:0] first,
                            output int span);
    logic        x;
    int          c;
    logic [31:0] d;
    span = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && mode == 1) begin
        drive_cycle(1'b0, 32'h0, x);
        span++;
      end
      if (mode == 2) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) drive_cycle(1'b0, 32'h0, x);
      end
      if (!rnd) d = 32'(k + 1) << 16;
      else if (k == 0) d = first;
      else d = $urandom;
      send_sample(d, c);
      span += c;
      if (mode == 0 && k > 0) chk("b2b_one_cycle", c, 1);
    end
  endtask

  initial begin
    logic x;
    int   span;

    do_reset();
    chk("ready_first_cycle", s_ready, 1'b0);

    // 8 back-to-back samples 0x00010000..0x00080000
    send_frame(0, 1'b0, 32'h0, span);
    finish_frame(1'b0);

    // WAIT holds off input despite s_valid
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, $urandom, x);
      chk("wait_ready_low", s_ready, 1'b0);
      chk("wait_no_req", mem_req, 1'b0);
    end
    done_pulse();

    // toggled valid: 8 writes over 15 cycles
    send_frame(1, 1'b1, $urandom, span);
    chk("toggle_span", span, 15);
    finish_frame(1'b0);
    done_pulse();

    // reset after 5 transfers discards the partial frame
    for (int k = 0; k < 5; k++) send_sample($urandom, span);
    drive_cycle(1'b0, 32'h0, x);
    chk("partial_no_start", start_cnt, 2);
    do_reset();
    send_frame(2, 1'b1, $urandom, span);
    finish_frame(1'b0);
    done_pulse();

    // fft_done held high across 3 frames; first sample exercises scaling
    fft_done = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(2, 1'b1, (f == 0) ? 32'h8000_7FF8 : $urandom, span);
      chk("held_no_early_inc", frame_cnt, exp_frames);
      finish_frame(1'b1);
    end
    fft_done = 1'b0;

    // frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    drive_cycle(1'b0, 32'h0, x);
    release dut.r_frame_cnt;
    drive_cycle(1'b0, 32'h0, x);
    exp_frames = 16'hFFFF;
    chk("frame_cnt_preload", frame_cnt, exp_frames);
    send_frame(2, 1'b1, $urandom, span);
    finish_frame(1'b0);
    done_pulse();
    chk("frame_cnt_wrap", frame_cnt, 16'h0000);

    drive_cycle(1'b0, 32'h0, x);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
